vga_ctrl_must: RTL and testbench

Timing controller for the 640x480@60 Hz VGA output path. Generates the horizontal and vertical counters, active-low sync pulses and the pixel request coordinates that drive the combinational picture generator (`vga_pic_must`). Registers the returned RGB565 `pix_data` into the active-video window and blanks it everywhere else. Sits between the picture generator and the board VGA pins, and provides a frame pulse and frame counter for per-frame schedulers.

---
 rtl/vga_ctrl_must_if.sv | 29 ++
 rtl/vga_ctrl_must.sv | 114 +++++++++++
 tb/tb_vga_ctrl_must.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_ctrl_must_if.sv
// vga_ctrl_must_if: signal bundle between the VGA timing controller, the
// combinational picture generator and the board VGA pins.
//   pix_data    : RGB565 from the picture generator for (pix_x, pix_y)
//   pix_x/pix_y : requested column/row, 10'h3FF when no request
//   hsync/vsync : active-low sync pulses
//   rgb         : registered pixel to the DAC, zero outside active video
//   frame_start : one-cycle pulse at counter position (0,0)
//   frame_cnt   : completed-frame counter
// master = timing controller side, slave = generator/consumer side.
interface vga_ctrl_must_if;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  modport master (
    input  pix_data,
    output pix_x, pix_y, hsync, vsync, rgb, frame_start, frame_cnt
  );

  modport slave (
    output pix_data,
    input  pix_x, pix_y, hsync, vsync, rgb, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_ctrl_must.sv
// vga_ctrl_must: 640x480@60 Hz VGA timing controller.
// Generates horizontal/vertical counters, active-low syncs and pixel request
// coordinates, registers the returned pixel into the active window and blanks
// it elsewhere. Provides a frame pulse and a completed-frame counter.
// Ports:
//   vga_clk   : pixel clock, the only clock
//   sys_rst_n : asynchronous active-low reset
//   vga_if    : vga_ctrl_must_if.master (pix_data in; pix_x, pix_y, hsync,
//               vsync, rgb, frame_start, frame_cnt out)
// Build option: define VGA_BORDER_EN to force a one-pixel red border
// (16'hF800) around the active picture.
module vga_ctrl_must #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_VALID = 640,
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_VALID = 480,
  parameter int unsigned V_FRONT = 10
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  vga_ctrl_must_if.master   vga_if
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int unsigned H_ACT   = H_SYNC + H_BACK;
  localparam int unsigned V_ACT   = V_SYNC + V_BACK;

  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncEnd = 10'(H_SYNC);
  localparam logic [9:0] VSyncEnd = 10'(V_SYNC);
  // Request runs one clock ahead of display to cover the rgb register.
  localparam logic [9:0] HReqLo   = 10'(H_ACT - 1);
  localparam logic [9:0] HReqHi   = 10'(H_ACT + H_VALID - 2);
  localparam logic [9:0] VReqLo   = 10'(V_ACT);
  localparam logic [9:0] VReqHi   = 10'(V_ACT + V_VALID - 1);
`ifdef VGA_BORDER_EN
  localparam logic [9:0] XLast    = 10'(H_VALID - 1);
  localparam logic [9:0] YLast    = 10'(V_VALID - 1);
`endif

  logic [9:0]  cnt_h_q, cnt_h_d;
  logic [9:0]  cnt_v_q, cnt_v_d;
  logic [15:0] rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        line_end;
  logic        frame_end;
  logic        pix_req;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_comb begin
    line_end  = (cnt_h_q == HLast);
    frame_end = line_end && (cnt_v_q == VLast);

    cnt_h_d = line_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d = cnt_v_q;
    if (line_end) begin
      cnt_v_d = (cnt_v_q == VLast) ? 10'd0 : cnt_v_q + 10'd1;
    end

    pix_req = (cnt_h_q >= HReqLo) && (cnt_h_q <= HReqHi) &&
              (cnt_v_q >= VReqLo) && (cnt_v_q <= VReqHi);
    pix_x   = pix_req ? (cnt_h_q - HReqLo) : 10'h3FF;
    pix_y   = pix_req ? (cnt_v_q - VReqLo) : 10'h3FF;

    rgb_d = 16'h0000;
    if (pix_req) begin
      rgb_d = vga_if.pix_data;
`ifdef VGA_BORDER_EN
      if ((pix_x == 10'd0) || (pix_x == XLast) || (pix_y == 10'd0) || (pix_y == YLast)) begin
        rgb_d = 16'hF800;
      end
`endif
    end

    // Pulse lands on the edge that wraps both counters, i.e. during (0,0).
    frame_start_d = frame_end;
    frame_cnt_d   = frame_cnt_q + 8'(frame_end);
  end

  always_comb begin
    vga_if.pix_x       = pix_x;
    vga_if.pix_y       = pix_y;
    vga_if.hsync       = (cnt_h_q >= HSyncEnd);
    vga_if.vsync       = (cnt_v_q >= VSyncEnd);
    vga_if.rgb         = rgb_q;
    vga_if.frame_start = frame_start_q;
    vga_if.frame_cnt   = frame_cnt_q;
  end

endmodule

// File: tb/tb_vga_ctrl_must.sv
// Bench for vga_ctrl_must. A default-parameter instance is checked against a
// table of timing points on the first lines; a small-parameter instance runs
// random pixel data over more than 256 frames against a reference model that
// derives every output from the number of clocks since reset release.
module tb_vga_ctrl_must;

  // Small instance geometry: 14 clocks per line, 8 lines per frame.
  localparam int SH_SYNC = 4, SH_BACK = 2, SH_VALID = 6, SH_FRONT = 2;
  localparam int SV_SYNC = 1, SV_BACK = 2, SV_VALID = 4, SV_FRONT = 1;
  localparam int S_HT    = SH_SYNC + SH_BACK + SH_VALID + SH_FRONT;
  localparam int S_VT    = SV_SYNC + SV_BACK + SV_VALID + SV_FRONT;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int S_HACT  = SH_SYNC + SH_BACK;
  localparam int S_VACT  = SV_SYNC + SV_BACK;

  logic        clk = 1'b0;
  logic        rst_full_n;
  logic        rst_small_n;
  logic [15:0] small_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #20 clk = ~clk;

  vga_ctrl_must_if if_full ();
  vga_ctrl_must_if if_small ();

  // Stub generator: {row[5:0], column}.
  assign if_full.pix_data  = {if_full.pix_y[5:0], if_full.pix_x};
  assign if_small.pix_data = small_data;

  vga_ctrl_must u_full (
    .vga_clk   (clk),
    .sys_rst_n (rst_full_n),
    .vga_if    (if_full)
  );

  vga_ctrl_must #(
    .H_SYNC  (SH_SYNC),
    .H_BACK  (SH_BACK),
    .H_VALID (SH_VALID),
    .H_FRONT (SH_FRONT),
    .V_SYNC  (SV_SYNC),
    .V_BACK  (SV_BACK),
    .V_VALID (SV_VALID),
    .V_FRONT (SV_FRONT)
  ) u_small (
    .vga_clk   (clk),
    .sys_rst_n (rst_small_n),
    .vga_if    (if_small)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bord(input int x, input int y, input int hv, input int vv,
                                       input logic [15:0] d);
`ifdef VGA_BORDER_EN
    if (x == 0 || x == hv - 1 || y == 0 || y == vv - 1) return 16'hF800;
`endif
    return d;
  endfunction

  function automatic logic [15:0] stub(input int x, input int y);
    logic [5:0] yy;
    logic [9:0] xx;
    yy = 6'(y);
    xx = 10'(x);
    return {yy, xx};
  endfunction

  // Table for the default-parameter instance; t = clocks since release.
  // rx < 0 means rgb must be 0, else rgb shows the pixel requested at (rx,ry).
  typedef struct {
    int         t;
    logic       hs;
    logic       vs;
    logic [9:0] px;
    logic [9:0] py;
    int         rx;
    int         ry;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int t, input logic hs, input logic vs, input logic [9:0] px,
                     input logic [9:0] py, input int rx, input int ry);
    vec_t v;
    v.t = t; v.hs = hs; v.vs = vs; v.px = px; v.py = py; v.rx = rx; v.ry = ry;
    vecs.push_back(v);
  endtask

  // Small-instance reference: position from elapsed clocks, rgb from the
  // previous cycle's request and the data driven then.
  task automatic run_small(input int n);
    logic [15:0] exp_rgb;
    logic [15:0] nxt_rgb;
    exp_rgb = 16'h0000;
    for (int t = 0; t < n; t++) begin
      int h, v, x, y;
      logic req, hs, vs, fs;
      logic [9:0] px, py;
      logic [7:0] fc;
      h   = t % S_HT;
      v   = (t / S_HT) % S_VT;
      req = (h >= S_HACT - 1) && (h <= S_HACT + SH_VALID - 2) &&
            (v >= S_VACT) && (v < S_VACT + SV_VALID);
      x   = h - (S_HACT - 1);
      y   = v - S_VACT;
      px  = req ? 10'(x) : 10'h3FF;
      py  = req ? 10'(y) : 10'h3FF;
      hs  = (h >= SH_SYNC);
      vs  = (v >= SV_SYNC);
      fs  = (t > 0) && (t % S_FRAME == 0);
      fc  = 8'((t / S_FRAME) % 256);
      check("small_outputs",
            {17'd0, if_small.hsync, if_small.vsync, if_small.pix_x, if_small.pix_y,
             if_small.rgb, if_small.frame_start, if_small.frame_cnt},
            {17'd0, hs, vs, px, py, exp_rgb, fs, fc});
      small_data = 16'($urandom);
      nxt_rgb = req ? bord(x, y, SH_VALID, SV_VALID, small_data) : 16'h0000;
      @(negedge clk);
      exp_rgb = nxt_rgb;
    end
  endtask

  task automatic check_reset_small(input string name);
    check(name, {17'd0, if_small.hsync, if_small.vsync, if_small.pix_x, if_small.pix_y,
                 if_small.rgb, if_small.frame_start, if_small.frame_cnt},
          {17'd0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0, 8'h00});
  endtask

  initial begin
    int cur;
    rst_full_n  = 1'b0;
    rst_small_n = 1'b0;
    small_data  = 16'h0000;

    add(0,     1'b0, 1'b0, 10'h3FF, 10'h3FF, -1,  0);
    add(95,    1'b0, 1'b0, 10'h3FF, 10'h3FF, -1,  0);
    add(96,    1'b1, 1'b0, 10'h3FF, 10'h3FF, -1,  0);
    add(799,   1'b1, 1'b0, 10'h3FF, 10'h3FF, -1,  0);
    add(800,   1'b0, 1'b0, 10'h3FF, 10'h3FF, -1,  0);
    add(1599,  1'b1, 1'b0, 10'h3FF, 10'h3FF, -1,  0);
    add(1600,  1'b0, 1'b1, 10'h3FF, 10'h3FF, -1,  0);
    add(27700, 1'b1, 1'b1, 10'h3FF, 10'h3FF, -1,  0);
    add(28142, 1'b1, 1'b1, 10'h3FF, 10'h3FF, -1,  0);
    add(28143, 1'b1, 1'b1, 10'd0,   10'd0,   -1,  0);
    add(28144, 1'b1, 1'b1, 10'd1,   10'd0,    0,  0);
    add(28149, 1'b1, 1'b1, 10'd6,   10'd0,    5,  0);
    add(28782, 1'b1, 1'b1, 10'd639, 10'd0,  638,  0);
    add(28783, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 639, 0);
    add(28784, 1'b1, 1'b1, 10'h3FF, 10'h3FF, -1,  0);
    add(28850, 1'b0, 1'b1, 10'h3FF, 10'h3FF, -1,  0);
    add(28953, 1'b1, 1'b1, 10'd10,  10'd1,    9,  1);

    repeat (10) @(negedge clk);
    check("full_reset_hsync", 64'(if_full.hsync), 64'(1'b0));
    check("full_reset_vsync", 64'(if_full.vsync), 64'(1'b0));
    check("full_reset_pix_x", 64'(if_full.pix_x), 64'(10'h3FF));
    check("full_reset_rgb",   64'(if_full.rgb),   64'(16'h0000));
    check_reset_small("small_reset");

    // Default geometry: table of timing points after release.
    rst_full_n = 1'b1;
    cur = 0;
    foreach (vecs[i]) begin
      logic [15:0] er;
      repeat (vecs[i].t - cur) @(negedge clk);
      cur = vecs[i].t;
      er = (vecs[i].rx < 0) ? 16'h0000 :
           bord(vecs[i].rx, vecs[i].ry, 640, 480, stub(vecs[i].rx, vecs[i].ry));
      check($sformatf("full_hsync_t%0d", cur), 64'(if_full.hsync), 64'(vecs[i].hs));
      check($sformatf("full_vsync_t%0d", cur), 64'(if_full.vsync), 64'(vecs[i].vs));
      check($sformatf("full_pix_x_t%0d", cur), 64'(if_full.pix_x), 64'(vecs[i].px));
      check($sformatf("full_pix_y_t%0d", cur), 64'(if_full.pix_y), 64'(vecs[i].py));
      check($sformatf("full_rgb_t%0d", cur),   64'(if_full.rgb),   64'(er));
      check($sformatf("full_frame_t%0d", cur),
            64'({if_full.frame_start, if_full.frame_cnt}), 64'(9'd0));
    end
    check_reset_small("small_still_in_reset");

    // Small geometry: random pixel data across the frame_cnt wrap.
    rst_small_n = 1'b1;
    run_small(257 * S_FRAME + 40);

    // Asynchronous reset mid-frame, asserted between clock edges.
    repeat ($urandom_range(20, 90)) @(negedge clk);
    @(posedge clk);
    #7;
    rst_small_n = 1'b0;
    #1;
    check_reset_small("small_async_reset");
    @(negedge clk);
    check_reset_small("small_reset_held");
    rst_small_n = 1'b1;
    run_small(3 * S_FRAME + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
